// File: rtl/p_dec_2x4_seq_pkg.sv
// Shared types and decode constants for the buffered 2-to-4 decoder.
package p_dec_2x4_seq_pkg;

  localparam int ENTRY_W = 3;

  typedef struct packed {
    logic       v;
    logic [1:0] y;
  } entry_t;

  localparam logic [3:0] DEC_Y0   = 4'b1000;
  localparam logic [3:0] DEC_Y1   = 4'b0100;
  localparam logic [3:0] DEC_Y2   = 4'b0010;
  localparam logic [3:0] DEC_Y3   = 4'b0001;
  localparam logic [3:0] DEC_NONE = 4'b0000;

  function automatic logic [3:0] dec_onehot(input entry_t e);
    logic [3:0] d;
    d = DEC_NONE;
    if (e.v) begin
      case (e.y)
        2'b00:   d = DEC_Y0;
        2'b01:   d = DEC_Y1;
        2'b10:   d = DEC_Y2;
        default: d = DEC_Y3;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/p_dec_fifo.sv
// Small ready/valid FIFO with wrapping pointers and an explicit occupancy count.
module p_dec_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_valid_i,
  output logic             push_ready_o,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             pop_valid_o,
  input  logic             pop_ready_i,
  output logic [WIDTH-1:0] pop_data_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             push, pop;

  assign push_ready_o = (occ_q != FULL);
  assign pop_valid_o  = (occ_q != '0);
  assign pop_data_o   = mem[rd_q];

  // A flush wins over any same-cycle traffic.
  assign push = push_valid_i & push_ready_o & ~clr_i;
  assign pop  = pop_ready_i & pop_valid_o & ~clr_i;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    if (clr_i) begin
      wr_d  = '0;
      rd_d  = '0;
      occ_d = '0;
    end else begin
      if (push) wr_d = (wr_q == LAST) ? '0 : wr_q + 1'b1;
      if (pop)  rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
      case ({push, pop})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/p_dec_2x4_seq.sv
// Buffered 2-to-4 decoder: queues priority-encoder codes, decodes the head, counts valid codes.
module p_dec_2x4_seq
  import p_dec_2x4_seq_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_v,
  input  logic [1:0]       in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_d,
  output logic             out_none,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  entry_t             wr_e, head_e;
  logic [ENTRY_W-1:0] head_raw;
  logic [CNT_W-1:0]   evt_cnt_q, evt_cnt_d;
  logic               accept;

  assign wr_e = '{v: in_v, y: in_y};

  p_dec_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (clr),
    .push_valid_i(in_valid),
    .push_ready_o(in_ready),
    .push_data_i (wr_e),
    .pop_valid_o (out_valid),
    .pop_ready_i (out_ready),
    .pop_data_o  (head_raw)
  );

  assign head_e   = entry_t'(head_raw);
  assign out_d    = out_valid ? dec_onehot(head_e) : DEC_NONE;
  assign out_none = out_valid & ~head_e.v;

  assign accept = in_valid & in_ready;

  always_comb begin
    evt_cnt_d = evt_cnt_q;
    if (clr)                                          evt_cnt_d = '0;
    else if (accept && in_v && evt_cnt_q != CNT_MAX)  evt_cnt_d = evt_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) evt_cnt_q <= '0;
    else        evt_cnt_q <= evt_cnt_d;
  end

  assign evt_cnt = evt_cnt_q;

endmodule

// File: tb/tb_p_dec_2x4_seq.sv
// Bench for p_dec_2x4_seq: vector table plus scoreboarded hand sequences.
module tb_p_dec_2x4_seq;

  localparam int DEPTH = 2;
  localparam int CNT_W = 3;
  localparam int CMAX  = 7;

  logic             clk = 1'b0;
  logic             rst_n, clr, in_valid, in_ready, in_v;
  logic [1:0]       in_y;
  logic             out_valid, out_ready, out_none;
  logic [3:0]       out_d;
  logic [CNT_W-1:0] evt_cnt;

  int nvec = 0;
  int nerr = 0;
  logic [2:0] sb[$];
  int cnt_m = 0;

  typedef struct {
    logic       iv;
    logic       v;
    logic [1:0] y;
    logic       ordy;
    logic       exp_vld;
    logic [3:0] exp_d;
    logic       exp_none;
    int         exp_cnt;
  } vec_t;
  vec_t tbl[8];

  p_dec_2x4_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_v     (in_v),
    .in_y     (in_y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_d    (out_d),
    .out_none (out_none),
    .evt_cnt  (evt_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] dec_model(input logic [2:0] e);
    if (!e[2]) return 4'b0000;
    case (e[1:0])
      2'd0:    return 4'b1000;
      2'd1:    return 4'b0100;
      2'd2:    return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a falling edge; samples pre-edge, advances one cycle, samples again.
  task automatic step(input logic iv, input logic v, input logic [1:0] y,
                      input logic ordy, input logic c);
    logic exp_rdy, exp_vld, acc, pop;
    in_valid = iv; in_v = v; in_y = y; out_ready = ordy; clr = c;
    #1;
    exp_rdy = (sb.size() < DEPTH);
    exp_vld = (sb.size() > 0);
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, exp_vld);
    if (exp_vld) begin
      check("out_d", out_d, dec_model(sb[0]));
      check("out_none", out_none, !sb[0][2]);
    end else begin
      check("out_d_idle", out_d, 0);
      check("out_none_idle", out_none, 0);
    end
    acc = iv && exp_rdy && !c;
    pop = ordy && exp_vld && !c;
    @(posedge clk);
    if (c) begin
      sb.delete();
      cnt_m = 0;
    end else begin
      if (pop) void'(sb.pop_front());
      if (acc) begin
        sb.push_back({v, y});
        if (v && cnt_m != CMAX) cnt_m++;
      end
    end
    @(negedge clk);
    check("evt_cnt", evt_cnt, cnt_m);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 4'b0000, 1'b0, 1};
    tbl[1] = '{1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 4'b1000, 1'b0, 2};
    tbl[2] = '{1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 4'b0100, 1'b0, 3};
    tbl[3] = '{1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 4'b0010, 1'b0, 4};
    tbl[4] = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 4'b0001, 1'b0, 4};
    tbl[5] = '{1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 4'b0000, 1'b0, 4};
    tbl[6] = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 4'b0000, 1'b1, 4};
    tbl[7] = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 4'b0000, 1'b0, 4};

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_v = 1'b0; in_y = 2'b00; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_d", out_d, 0);
    check("rst_out_none", out_none, 0);
    check("rst_evt_cnt", evt_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Four decodes back to back, then an in_v=0 code.
    for (int i = 0; i < 8; i++) begin
      check("tbl_out_valid", out_valid, tbl[i].exp_vld);
      check("tbl_out_d", out_d, tbl[i].exp_d);
      check("tbl_out_none", out_none, tbl[i].exp_none);
      step(tbl[i].iv, tbl[i].v, tbl[i].y, tbl[i].ordy, 1'b0);
      check("tbl_evt_cnt", evt_cnt, tbl[i].exp_cnt);
    end

    // Back-pressure: third code held until the consumer drains.
    step(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    check("full_in_ready", in_ready, 0);
    step(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
    step(1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
    step(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    check("drained_out_valid", out_valid, 0);

    // Counter saturation after a flush.
    step(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 2'(i), 1'b1, 1'b0);
    check("sat_evt_cnt", evt_cnt, 7);
    step(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);

    // Steady push+pop at occupancy 1 across several pointer wraps.
    step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, i[0], 2'(i + 1), 1'b1, 1'b0);
    step(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    check("wrap_drained", out_valid, 0);

    // Asynchronous reset while full.
    step(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    step(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_out_d", out_d, 0);
    check("arst_out_none", out_none, 0);
    check("arst_evt_cnt", evt_cnt, 0);
    sb.delete();
    cnt_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Synchronous flush while full, with a push and pop offered in the same cycle.
    step(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'b01, 1'b1, 1'b1);
    check("clr_out_valid", out_valid, 0);
    check("clr_in_ready", in_ready, 1);
    step(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
